// File: rtl/key_debounce_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared definitions for the key debouncer: key index
//               constants, the per-key FSM state type, a counter sizing helper
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_FIRE  = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Width that holds the largest of the three sample counts without wrapping
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_if.sv
// ============================================================================
// Module      : key_debounce_if
// Description : Key front-end bundle: sampling strobe in, raw keys in,
//               debounced levels and event pulses out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface key_debounce_if #(
    parameter int NKEYS = 5
);
    import key_pkg::*;

    logic             sample_clk;
    logic [NKEYS-1:0] key_raw;
    logic             sample_tick;
    logic [NKEYS-1:0] key_level;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic [NKEYS-1:0] key_repeat;

    // Key source / game logic side
    modport master (
        output sample_clk, key_raw,
        input  sample_tick, key_level, key_press, key_release, key_repeat
    );

    // Debouncer side
    modport slave (
        input  sample_clk, key_raw,
        output sample_tick, key_level, key_press, key_release, key_repeat
    );

endinterface

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// ============================================================================
// Module      : key_channel
// Description : One key: 2-FF synchronizer, polarity normalisation and the
//               debounce / auto-repeat FSM advanced by the sample tick
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_channel
    import key_pkg::*;
#(
    parameter int STABLE          = 4,
    parameter int REPEAT_DELAY    = 25,
    parameter int REPEAT_RATE     = 5,
    parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
    input  wire logic clk_in,
    input  wire logic rst_n,
    input  wire logic tick,
    input  wire logic raw,
    output logic      level,
    output logic      press_pulse,
    output logic      release_pulse,
    output logic      repeat_pulse
);

    localparam int CW = cnt_width(STABLE, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] STABLE_C  = CW'(STABLE);
    localparam logic [CW-1:0] DELAY_C   = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RATE_C    = CW'(REPEAT_RATE);

    logic          sync1;
    logic          sync2;
    logic          active;
    key_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rep;
    logic          first;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] rep_inc;

    assign active  = KEY_ACTIVE_HIGH ? sync2 : ~sync2;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign rep_inc = (rep == CNT_MAX) ? rep : rep + CW'(1);

    // Bring the asynchronous key pin into the clk_in domain
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce and auto-repeat state machine; moves only on a sample tick
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rep           <= '0;
            first         <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (active) begin
                            if (STABLE == 1) begin
                                state       <= HELD;
                                press_pulse <= 1'b1;
                                level       <= 1'b1;
                                rep         <= '0;
                                first       <= 1'b1;
                                cnt         <= '0;
                            end else begin
                                state <= PRESS_WAIT;
                                cnt   <= CW'(1);
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (active) begin
                            if (cnt_inc >= STABLE_C) begin
                                state       <= HELD;
                                press_pulse <= 1'b1;
                                level       <= 1'b1;
                                rep         <= '0;
                                first       <= 1'b1;
                                cnt         <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (active) begin
                            if (first && (rep_inc >= DELAY_C)) begin
                                repeat_pulse <= 1'b1;
                                rep          <= '0;
                                first        <= 1'b0;
                            end else if (!first && (rep_inc >= RATE_C)) begin
                                repeat_pulse <= 1'b1;
                                rep          <= '0;
                            end else begin
                                rep <= rep_inc;
                            end
                        end else if (STABLE == 1) begin
                            state         <= IDLE;
                            release_pulse <= 1'b1;
                            level         <= 1'b0;
                            cnt           <= '0;
                        end else begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!active) begin
                            if (cnt_inc >= STABLE_C) begin
                                state         <= IDLE;
                                release_pulse <= 1'b1;
                                level         <= 1'b0;
                                cnt           <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            // A short release glitch resumes the hold where it left off
                            state <= HELD;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Key front end: turns the divider square wave into a one-cycle
//               sample strobe and debounces NKEYS independent key channels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce
    import key_pkg::*;
#(
    parameter int NKEYS           = 5,
    parameter int STABLE          = 4,
    parameter int REPEAT_DELAY    = 25,
    parameter int REPEAT_RATE     = 5,
    parameter bit KEY_ACTIVE_HIGH = 1'b1
) (
    input  wire logic     clk_in,
    input  wire logic     rst_n,
    key_debounce_if.slave bus
);

    logic samp_sync1;
    logic samp_sync2;
    logic samp_prev;
    logic tick;

    // Synchronise the divider output and register its rising edge as a strobe
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            samp_sync1 <= 1'b0;
            samp_sync2 <= 1'b0;
            samp_prev  <= 1'b0;
            tick       <= 1'b0;
        end else begin
            samp_sync1 <= bus.sample_clk;
            samp_sync2 <= samp_sync1;
            samp_prev  <= samp_sync2;
            tick       <= samp_sync2 & ~samp_prev;
        end
    end

    assign bus.sample_tick = tick;

    generate
        for (genvar i = 0; i < NKEYS; i++) begin : g_key
            key_channel #(
                .STABLE          (STABLE),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .KEY_ACTIVE_HIGH (KEY_ACTIVE_HIGH)
            ) u_channel (
                .clk_in        (clk_in),
                .rst_n         (rst_n),
                .tick          (tick),
                .raw           (bus.key_raw[i]),
                .level         (bus.key_level[i]),
                .press_pulse   (bus.key_press[i]),
                .release_pulse (bus.key_release[i]),
                .repeat_pulse  (bus.key_repeat[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// Module      : tb_key_debounce
// Description : Directed bench: default active-high debouncer plus an
//               active-low STABLE=1 instance sharing clock, reset and strobe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;
    import key_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    key_debounce_if #(.NKEYS(5)) bus_a ();
    key_debounce_if #(.NKEYS(5)) bus_b ();

    key_debounce #(
        .NKEYS(5), .STABLE(4), .REPEAT_DELAY(25), .REPEAT_RATE(5), .KEY_ACTIVE_HIGH(1'b1)
    ) u_dut_a (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus_a)
    );

    key_debounce #(
        .NKEYS(5), .STABLE(1), .REPEAT_DELAY(25), .REPEAT_RATE(5), .KEY_ACTIVE_HIGH(1'b0)
    ) u_dut_b (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Captures over one sample period (OR of pulses, first negedge index seen)
    logic [4:0] cap_press_a, cap_rel_a, cap_rep_a;
    logic [4:0] cap_press_b, cap_rel_b;
    int         idx_press_a, idx_tick_a, idx_press_b, idx_rel_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample period: sample_clk high for 4 cycles, low for 4
    task automatic do_tick();
        cap_press_a = '0; cap_rel_a = '0; cap_rep_a = '0;
        cap_press_b = '0; cap_rel_b = '0;
        idx_press_a = 0; idx_tick_a = 0; idx_press_b = 0; idx_rel_b = 0;
        @(negedge clk);
        bus_a.sample_clk = 1'b1;
        bus_b.sample_clk = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus_a.sample_tick   && idx_tick_a  == 0) idx_tick_a  = n;
            if (|bus_a.key_press    && idx_press_a == 0) idx_press_a = n;
            if (|bus_b.key_press    && idx_press_b == 0) idx_press_b = n;
            if (|bus_b.key_release  && idx_rel_b   == 0) idx_rel_b   = n;
            cap_press_a |= bus_a.key_press;
            cap_rel_a   |= bus_a.key_release;
            cap_rep_a   |= bus_a.key_repeat;
            cap_press_b |= bus_b.key_press;
            cap_rel_b   |= bus_b.key_release;
            if (n == 4) begin
                bus_a.sample_clk = 1'b0;
                bus_b.sample_clk = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  acc_p, acc_r;
        logic [63:0] rep_mask;
        int          npress;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_a.sample_clk = 1'b0;
        bus_b.sample_clk = 1'b0;
        bus_a.key_raw    = 5'h00;
        bus_b.key_raw    = 5'h1F;
        repeat (3) @(negedge clk);
        chk("reset_a_outputs", 32'({bus_a.sample_tick, bus_a.key_level, bus_a.key_press,
                                    bus_a.key_release, bus_a.key_repeat}), 32'h0);
        chk("reset_b_outputs", 32'({bus_b.sample_tick, bus_b.key_level, bus_b.key_press,
                                    bus_b.key_release, bus_b.key_repeat}), 32'h0);
        rst_n = 1'b1;
        do_tick();
        do_tick();
        chk("idle_level", 32'(bus_a.key_level), 32'h0);

        // Clean press on fire
        bus_a.key_raw[KEY_FIRE] = 1'b1;
        acc_p = '0;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            acc_p |= cap_press_a;
        end
        chk("fire_no_early_press", 32'(acc_p), 32'h0);
        do_tick();
        chk("fire_press", 32'(cap_press_a), 32'h10);
        chk("tick_latency", 32'(idx_tick_a), 32'd3);
        chk("fire_press_latency", 32'(idx_press_a), 32'd4);
        chk("fire_level", 32'(bus_a.key_level), 32'h10);
        bus_a.key_raw[KEY_FIRE] = 1'b0;
        acc_r = '0;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            acc_r |= cap_rel_a;
        end
        chk("fire_no_early_release", 32'(acc_r), 32'h0);
        do_tick();
        chk("fire_release", 32'(cap_rel_a), 32'h10);
        chk("fire_level_off", 32'(bus_a.key_level), 32'h0);

        // Bounce on key 0
        acc_p = '0;
        acc_r = '0;
        for (int t = 0; t < 20; t++) begin
            bus_a.key_raw[KEY_UP] = (t % 2 == 0);
            do_tick();
            acc_p |= cap_press_a;
            acc_r |= cap_rel_a;
        end
        bus_a.key_raw[KEY_UP] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            do_tick();
            acc_p |= cap_press_a;
            acc_r |= cap_rel_a;
        end
        chk("bounce_no_press", 32'(acc_p), 32'h0);
        chk("bounce_no_release", 32'(acc_r), 32'h0);
        chk("bounce_level", 32'(bus_a.key_level), 32'h0);

        // Auto-repeat on key 2
        bus_a.key_raw[KEY_LEFT] = 1'b1;
        npress = 0;
        for (int t = 1; t <= 4; t++) begin
            do_tick();
            if (cap_press_a[KEY_LEFT]) npress++;
        end
        rep_mask = '0;
        for (int t = 1; t <= 40; t++) begin
            do_tick();
            if (cap_press_a[KEY_LEFT]) npress++;
            if (cap_rep_a[KEY_LEFT])   rep_mask[t] = 1'b1;
        end
        chk("repeat_one_press", 32'(npress), 32'd1);
        chk("repeat_mask_lo", rep_mask[31:0], 32'h4200_0000);
        chk("repeat_mask_hi", rep_mask[63:32], 32'h0000_0108);

        // Release glitch on key 2
        bus_a.key_raw[KEY_LEFT] = 1'b0;
        acc_r = '0;
        do_tick(); acc_r |= cap_rel_a;
        do_tick(); acc_r |= cap_rel_a;
        bus_a.key_raw[KEY_LEFT] = 1'b1;
        do_tick(); acc_r |= cap_rel_a;
        chk("glitch_no_release", 32'(acc_r), 32'h0);
        chk("glitch_level", 32'(bus_a.key_level), 32'h04);
        bus_a.key_raw[KEY_LEFT] = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            acc_r |= cap_rel_a;
        end
        chk("glitch_no_early_release", 32'(acc_r), 32'h0);
        do_tick();
        chk("glitch_release", 32'(cap_rel_a), 32'h04);
        chk("glitch_level_off", 32'(bus_a.key_level), 32'h0);

        // Reset while key 1 is held
        bus_a.key_raw[KEY_DOWN] = 1'b1;
        for (int t = 1; t <= 4; t++) do_tick();
        chk("down_level", 32'(bus_a.key_level), 32'h02);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({bus_a.sample_tick, bus_a.key_level, bus_a.key_press,
                                        bus_a.key_release, bus_a.key_repeat}), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        acc_p = '0;
        acc_r = '0;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            acc_p |= cap_press_a;
            acc_r |= cap_rel_a;
        end
        chk("post_reset_no_press", 32'(acc_p), 32'h0);
        chk("post_reset_level", 32'(bus_a.key_level), 32'h0);
        do_tick();
        acc_r |= cap_rel_a;
        chk("post_reset_repress", 32'(cap_press_a), 32'h02);
        chk("post_reset_no_release", 32'(acc_r), 32'h0);
        bus_a.key_raw[KEY_DOWN] = 1'b0;

        // Active-low, STABLE=1 instance on key 3
        bus_b.key_raw[KEY_RIGHT] = 1'b0;
        do_tick();
        chk("b_press", 32'(cap_press_b), 32'h08);
        chk("b_press_latency", 32'(idx_press_b), 32'd4);
        chk("b_level", 32'(bus_b.key_level), 32'h08);
        bus_b.key_raw[KEY_RIGHT] = 1'b1;
        do_tick();
        chk("b_release", 32'(cap_rel_b), 32'h08);
        chk("b_release_latency", 32'(idx_rel_b), 32'd4);
        chk("b_level_off", 32'(bus_b.key_level), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
